// File: rtl/render_pipeline_sequencer_pkg.sv
// Shared types and width helpers for the render pipeline frame sequencer.
package render_pipeline_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    VTX_START  = 3'd1,
    VTX_WAIT   = 3'd2,
    PRIM_START = 3'd3,
    PRIM_WAIT  = 3'd4,
    SWAP_WAIT  = 3'd5,
    DONE       = 3'd6
  } seq_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 1048576;
  localparam int          DEFAULT_MAX_VERTEX_COUNT   = 4096;
  localparam int          DEFAULT_MAX_TRIANGLE_COUNT = 4096;

  // One extra bit so the maximum count itself is representable.
  function automatic int vtx_width(input int max_vertex_count);
    return $clog2(max_vertex_count) + 1;
  endfunction

  function automatic int tri_width(input int max_triangle_count);
    return $clog2(max_triangle_count) + 1;
  endfunction

endpackage

// File: rtl/render_pipeline_sequencer_if.sv
// Frame-control and stage handshake bundle for render_pipeline_sequencer.
// Optional perf counters appear when RENDER_SEQ_PERF_CNT_EN is defined.
interface render_pipeline_sequencer_if
  import render_pipeline_pkg::*;
#(
  parameter int VTX_W = vtx_width(DEFAULT_MAX_VERTEX_COUNT),
  parameter int TRI_W = tri_width(DEFAULT_MAX_TRIANGLE_COUNT)
);
  logic             frame_start_i;
  logic [VTX_W-1:0] vertex_count_i;
  logic [TRI_W-1:0] triangle_count_i;
  logic             frame_ready_o;
  logic             frame_done_o;
  logic             frame_error_o;
  logic             vtx_start_o;
  logic [VTX_W-1:0] vtx_count_o;
  logic             vtx_done_i;
  logic             prim_start_o;
  logic [TRI_W-1:0] prim_count_o;
  logic             prim_done_i;
  logic             vsync_i;
  logic             swap_o;
  logic             busy_o;
`ifdef RENDER_SEQ_PERF_CNT_EN
  logic [31:0]      perf_vtx_cycles_o;
  logic [31:0]      perf_prim_cycles_o;
  logic [31:0]      perf_frame_cycles_o;
`endif

  // Environment side: frame control, datapath stages and display.
  modport master (
    output frame_start_i, vertex_count_i, triangle_count_i,
    output vtx_done_i, prim_done_i, vsync_i,
    input  frame_ready_o, frame_done_o, frame_error_o,
    input  vtx_start_o, vtx_count_o, prim_start_o, prim_count_o,
    input  swap_o, busy_o
`ifdef RENDER_SEQ_PERF_CNT_EN
    , input perf_vtx_cycles_o, perf_prim_cycles_o, perf_frame_cycles_o
`endif
  );

  // Sequencer side.
  modport slave (
    input  frame_start_i, vertex_count_i, triangle_count_i,
    input  vtx_done_i, prim_done_i, vsync_i,
    output frame_ready_o, frame_done_o, frame_error_o,
    output vtx_start_o, vtx_count_o, prim_start_o, prim_count_o,
    output swap_o, busy_o
`ifdef RENDER_SEQ_PERF_CNT_EN
    , output perf_vtx_cycles_o, perf_prim_cycles_o, perf_frame_cycles_o
`endif
  );

endinterface

// File: rtl/render_pipeline_sequencer_watchdog.sv
// stage_watchdog: up-counter cleared on WAIT-state entry, counting while
// enabled; timeout fires in the cycle that completes LIMIT enabled cycles.
// LIMIT = 0 disables the timeout entirely.
module stage_watchdog #(
  parameter int unsigned LIMIT = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_limit;

  assign at_limit = (cnt == LAST);
  assign timeout  = (LIMIT != 0) && enable && at_limit;

  // Count enabled cycles; hold at the terminal value so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/render_pipeline_sequencer.sv
// render_pipeline_sequencer: frame-level controller for the render datapath.
// Sequence: vertex stage -> primitive stage -> vsync-aligned swap -> done.
// Optional macro RENDER_SEQ_PERF_CNT_EN adds per-stage cycle counters.
//
// state      | meaning
// IDLE       | ready for a frame request
// VTX_START  | one-cycle vertex stage start pulse
// VTX_WAIT   | waiting for vtx_done_i (watchdog running)
// PRIM_START | one-cycle primitive stage start pulse
// PRIM_WAIT  | waiting for prim_done_i (watchdog running)
// SWAP_WAIT  | waiting for vsync_i to swap buffers (watchdog running)
// DONE       | frame finished or aborted; frame_done_o follows
module render_pipeline_sequencer
  import render_pipeline_pkg::*;
#(
  parameter int          MAX_TRIANGLE_COUNT = DEFAULT_MAX_TRIANGLE_COUNT,
  parameter int          MAX_VERTEX_COUNT   = DEFAULT_MAX_VERTEX_COUNT,
  parameter int unsigned TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                        clk,
  input logic                        rst,
  render_pipeline_sequencer_if.slave bus
);
  localparam int VTX_W = vtx_width(MAX_VERTEX_COUNT);
  localparam int TRI_W = tri_width(MAX_TRIANGLE_COUNT);
  localparam logic [VTX_W-1:0] MAX_VTX = VTX_W'(MAX_VERTEX_COUNT);
  localparam logic [TRI_W-1:0] MAX_TRI = TRI_W'(MAX_TRIANGLE_COUNT);

  seq_state_t       state, state_next;
  logic             load, set_err, do_swap, wd_clear, wd_enable, wd_timeout;
  logic             counts_bad;
  logic             vtx_start_r, prim_start_r, swap_r, done_r, error_r;
  logic [VTX_W-1:0] vtx_cnt_r;
  logic [TRI_W-1:0] tri_cnt_r;

  // Range check on the counts being captured this cycle.
  assign counts_bad = (bus.vertex_count_i == '0) ||
                      (bus.vertex_count_i > MAX_VTX) ||
                      (bus.triangle_count_i > MAX_TRI);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a done strobe takes priority over a same-cycle timeout.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    set_err    = 1'b0;
    do_swap    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.frame_start_i) begin
          load = 1'b1;
          if (counts_bad) begin
            set_err    = 1'b1;
            state_next = DONE;
          end else begin
            state_next = VTX_START;
          end
        end
      end
      VTX_START: state_next = VTX_WAIT;
      VTX_WAIT: begin
        if (bus.vtx_done_i) begin
          state_next = (tri_cnt_r == '0) ? SWAP_WAIT : PRIM_START;
        end else if (wd_timeout) begin
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
      PRIM_START: state_next = PRIM_WAIT;
      PRIM_WAIT: begin
        if (bus.prim_done_i) begin
          state_next = SWAP_WAIT;
        end else if (wd_timeout) begin
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
      SWAP_WAIT: begin
        if (bus.vsync_i) begin
          do_swap    = 1'b1;
          state_next = DONE;
        end else if (wd_timeout) begin
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign wd_enable = (state == VTX_WAIT) || (state == PRIM_WAIT) || (state == SWAP_WAIT);
  assign wd_clear  = (state_next != state) &&
                     ((state_next == VTX_WAIT) || (state_next == PRIM_WAIT) ||
                      (state_next == SWAP_WAIT));

  stage_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .timeout (wd_timeout)
  );

  // Registered pulses, sticky error and latched counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      vtx_start_r  <= 1'b0;
      prim_start_r <= 1'b0;
      swap_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      vtx_cnt_r    <= '0;
      tri_cnt_r    <= '0;
    end else begin
      vtx_start_r  <= (state_next == VTX_START);
      prim_start_r <= (state_next == PRIM_START);
      swap_r       <= do_swap;
      done_r       <= (state == DONE);
      if (load) begin
        error_r   <= set_err;
        vtx_cnt_r <= bus.vertex_count_i;
        tri_cnt_r <= bus.triangle_count_i;
      end else if (set_err) begin
        error_r <= 1'b1;
      end
    end
  end

  assign bus.frame_ready_o = (state == IDLE);
  assign bus.busy_o        = (state != IDLE);
  assign bus.frame_done_o  = done_r;
  assign bus.frame_error_o = error_r;
  assign bus.vtx_start_o   = vtx_start_r;
  assign bus.prim_start_o  = prim_start_r;
  assign bus.swap_o        = swap_r;
  assign bus.vtx_count_o   = vtx_cnt_r;
  assign bus.prim_count_o  = tri_cnt_r;

`ifdef RENDER_SEQ_PERF_CNT_EN
  logic [31:0] vtx_cyc, prim_cyc, frame_cyc;
  logic [31:0] perf_vtx_r, perf_prim_r, perf_frame_r;

  // Saturating live counters restart on accept; results publish when DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      vtx_cyc      <= '0;
      prim_cyc     <= '0;
      frame_cyc    <= '0;
      perf_vtx_r   <= '0;
      perf_prim_r  <= '0;
      perf_frame_r <= '0;
    end else begin
      if (load) begin
        vtx_cyc   <= '0;
        prim_cyc  <= '0;
        frame_cyc <= '0;
      end else begin
        if (state == VTX_WAIT && vtx_cyc != '1)   vtx_cyc  <= vtx_cyc + 1'b1;
        if (state == PRIM_WAIT && prim_cyc != '1) prim_cyc <= prim_cyc + 1'b1;
        if (state != IDLE && state != DONE && frame_cyc != '1)
          frame_cyc <= frame_cyc + 1'b1;
      end
      if (state == DONE) begin
        perf_vtx_r   <= vtx_cyc;
        perf_prim_r  <= prim_cyc;
        perf_frame_r <= frame_cyc;
      end
    end
  end

  assign bus.perf_vtx_cycles_o   = perf_vtx_r;
  assign bus.perf_prim_cycles_o  = perf_prim_r;
  assign bus.perf_frame_cycles_o = perf_frame_r;
`endif

endmodule

// File: tb/tb_render_pipeline_sequencer.sv
// Directed bench for render_pipeline_sequencer with an event scoreboard.
module tb_render_pipeline_sequencer;
  import render_pipeline_pkg::*;

  localparam int VW = vtx_width(4096);
  localparam int TW = tri_width(4096);

  localparam int EV_VTX  = 0;
  localparam int EV_PRIM = 1;
  localparam int EV_SWAP = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];

  render_pipeline_sequencer_if #(.VTX_W(VW), .TRI_W(TW)) bus ();

  render_pipeline_sequencer #(
    .MAX_TRIANGLE_COUNT (4096),
    .MAX_VERTEX_COUNT   (4096),
    .TIMEOUT_CYCLES     (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk_ev(input int kind, input int data);
    ev_t e;
    n_assert++;
    assert (exp_q.size() != 0)
    else begin
      n_fail++;
      $error("FAIL unexpected_event observed=kind%0d/%0d expected=none", kind, data);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (e.kind == kind && e.data == data)
      else begin
        n_fail++;
        $error("FAIL event_order observed=kind%0d/%0d expected=kind%0d/%0d",
               kind, data, e.kind, e.data);
      end
    end
  endtask

  // Output monitor: each observed pulse must match the next expected event.
  always @(negedge clk) begin
    if (bus.vtx_start_o  === 1'b1) chk_ev(EV_VTX, int'(bus.vtx_count_o));
    if (bus.prim_start_o === 1'b1) chk_ev(EV_PRIM, int'(bus.prim_count_o));
    if (bus.swap_o       === 1'b1) chk_ev(EV_SWAP, 0);
    if (bus.frame_done_o === 1'b1) chk_ev(EV_DONE, int'(bus.frame_error_o));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic accept(input int v, input int t);
    bus.vertex_count_i   = VW'(v);
    bus.triangle_count_i = TW'(t);
    bus.frame_start_i    = 1'b1;
    tick();
    bus.frame_start_i    = 1'b0;
    bus.vertex_count_i   = VW'(99);
    bus.triangle_count_i = TW'(77);
  endtask

  task automatic pulse_vtx_done();
    bus.vtx_done_i = 1'b1;
    tick();
    bus.vtx_done_i = 1'b0;
  endtask

  task automatic pulse_prim_done();
    bus.prim_done_i = 1'b1;
    tick();
    bus.prim_done_i = 1'b0;
  endtask

  task automatic pulse_vsync();
    bus.vsync_i = 1'b1;
    tick();
    bus.vsync_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.frame_start_i    = 1'b0;
    bus.vertex_count_i   = '0;
    bus.triangle_count_i = '0;
    bus.vtx_done_i       = 1'b0;
    bus.prim_done_i      = 1'b0;
    bus.vsync_i          = 1'b0;
    cyc(3);
    chk("rst_ready", 32'(bus.frame_ready_o), 1);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_error", 32'(bus.frame_error_o), 0);
    chk("rst_vtx_count", 32'(bus.vtx_count_o), 0);
    chk("rst_prim_count", 32'(bus.prim_count_o), 0);
    rst = 1'b0;
    tick();

    // Nominal frame
    push(EV_VTX, 36); push(EV_PRIM, 12); push(EV_SWAP, 0); push(EV_DONE, 0);
    accept(36, 12);
    chk("nom_vtx_start_lat", 32'(bus.vtx_start_o), 1);
    chk("nom_ready_low", 32'(bus.frame_ready_o), 0);
    chk("nom_busy", 32'(bus.busy_o), 1);
    cyc(20);
    chk("nom_vtx_count_held", 32'(bus.vtx_count_o), 36);
    pulse_vtx_done();
    chk("nom_prim_start", 32'(bus.prim_start_o), 1);
    cyc(50);
    chk("nom_prim_count_held", 32'(bus.prim_count_o), 12);
    pulse_prim_done();
    cyc(10);
    pulse_vsync();
    chk("nom_swap", 32'(bus.swap_o), 1);
    tick();
    chk("nom_frame_done", 32'(bus.frame_done_o), 1);
    chk("nom_error", 32'(bus.frame_error_o), 0);
    chk("nom_ready_back", 32'(bus.frame_ready_o), 1);
`ifdef RENDER_SEQ_PERF_CNT_EN
    chk("perf_vtx", bus.perf_vtx_cycles_o, 20);
    chk("perf_prim", bus.perf_prim_cycles_o, 50);
    chk("perf_frame", bus.perf_frame_cycles_o, 83);
`endif

    // Zero vertex count
    push(EV_DONE, 1);
    accept(0, 5);
    chk("zv_error", 32'(bus.frame_error_o), 1);
    chk("zv_no_start", 32'(bus.vtx_start_o), 0);
    tick();
    chk("zv_done_2cyc", 32'(bus.frame_done_o), 1);

    // Zero triangle count: primitive stage skipped
    push(EV_VTX, 8); push(EV_SWAP, 0); push(EV_DONE, 0);
    accept(8, 0);
    chk("zt_error_cleared", 32'(bus.frame_error_o), 0);
    cyc(3);
    pulse_vtx_done();
    chk("zt_no_prim", 32'(bus.prim_start_o), 0);
    cyc(4);
    pulse_vsync();
    chk("zt_swap", 32'(bus.swap_o), 1);
    tick();

    // Primitive-stage timeout
    push(EV_VTX, 4); push(EV_PRIM, 2); push(EV_DONE, 1);
    accept(4, 2);
    cyc(1);
    pulse_vtx_done();
    tick();
    cyc(99);
    chk("to_no_err_99", 32'(bus.frame_error_o), 0);
    tick();
    chk("to_err_100", 32'(bus.frame_error_o), 1);
    chk("to_no_swap", 32'(bus.swap_o), 0);
    tick();
    chk("to_frame_done", 32'(bus.frame_done_o), 1);

    // Done strobe on the timeout cycle wins
    push(EV_VTX, 4); push(EV_PRIM, 2); push(EV_SWAP, 0); push(EV_DONE, 0);
    accept(4, 2);
    cyc(1);
    pulse_vtx_done();
    tick();
    cyc(99);
    pulse_prim_done();
    chk("tie_no_err", 32'(bus.frame_error_o), 0);
    chk("tie_busy", 32'(bus.busy_o), 1);
    pulse_vsync();
    tick();

    // Max counts accepted; strobes coinciding with start pulses are ignored
    push(EV_VTX, 4096); push(EV_PRIM, 4096); push(EV_SWAP, 0); push(EV_DONE, 0);
    accept(4096, 4096);
    pulse_vtx_done();
    chk("early_vtx_done_ignored", 32'(bus.prim_start_o), 0);
    cyc(2);
    pulse_vtx_done();
    pulse_prim_done();
    chk("early_prim_done_ignored", 32'(bus.busy_o), 1);
    pulse_prim_done();
    pulse_vsync();
    tick();
    chk("max_error", 32'(bus.frame_error_o), 0);

    // Out-of-range counts
    push(EV_DONE, 1);
    accept(4097, 1);
    tick();
    push(EV_DONE, 1);
    accept(5, 4097);
    chk("big_tri_error", 32'(bus.frame_error_o), 1);
    tick();

    // Stray frame_start and stray vtx_done
    push(EV_VTX, 10); push(EV_PRIM, 3); push(EV_SWAP, 0); push(EV_DONE, 0);
    bus.vertex_count_i   = VW'(10);
    bus.triangle_count_i = TW'(3);
    bus.frame_start_i    = 1'b1;
    tick();
    cyc(2);
    pulse_vtx_done();
    tick();
    pulse_vtx_done();
    chk("stray_no_prim", 32'(bus.prim_start_o), 0);
    chk("stray_busy", 32'(bus.busy_o), 1);
    chk("stray_count_held", 32'(bus.vtx_count_o), 10);
    cyc(2);
    pulse_prim_done();
    bus.frame_start_i = 1'b0;
    pulse_vsync();
    tick();
    chk("stray_ready", 32'(bus.frame_ready_o), 1);

    // Reset during PRIM_WAIT
    push(EV_VTX, 7); push(EV_PRIM, 7);
    accept(7, 7);
    cyc(1);
    pulse_vtx_done();
    tick();
    cyc(3);
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", 32'(bus.frame_ready_o), 1);
    chk("rst_mid_busy", 32'(bus.busy_o), 0);
`ifdef RENDER_SEQ_PERF_CNT_EN
    chk("rst_perf_vtx", bus.perf_vtx_cycles_o, 0);
    chk("rst_perf_prim", bus.perf_prim_cycles_o, 0);
    chk("rst_perf_frame", bus.perf_frame_cycles_o, 0);
`endif
    rst = 1'b0;
    cyc(3);
    pulse_vsync();
    cyc(3);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
